// File: rtl/clock_gen_bank.sv
// ============================================================================
// clock_gen_bank : bank of NUM_CH programmable clock/tick generators.
// Optional: CLOCK_GEN_BANK_SYNC_EN adds a 'sync' input for phase alignment.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_gen_bank #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 16,
  parameter int CH_W   = 2,
  parameter logic [NUM_CH*DIV_W-1:0] RST_DIV = {16'd4, 16'd12500, 16'd1302}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLOCK_GEN_BANK_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_low  = 2'd1;
  localparam logic [1:0] c_high = 2'd2;

  logic w_sync;
`ifdef CLOCK_GEN_BANK_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] c_idx = CH_W'(i);

    logic [1:0]       r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_active, w_active_nxt, r_shadow, w_shadow_nxt;
    logic [DIV_W-1:0] w_ratio, w_low;
    logic             r_clk, r_tick, r_pend;
    logic             w_clk_nxt, w_tick_nxt, w_pend_nxt;
    logic             w_hit, w_boundary, w_apply;

    // The counter spans the whole period; the first w_low counts are LOW.
    assign w_ratio    = (r_active < DIV_W'(2)) ? DIV_W'(2) : r_active;
    assign w_low      = w_ratio >> 1;
    assign w_boundary = (r_state == c_high) && (r_cnt == w_ratio - DIV_W'(1));
    assign w_hit      = cfg_we && (cfg_ch == c_idx);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= c_idle;
        r_cnt    <= '0;
        r_active <= RST_DIV[i*DIV_W +: DIV_W];
        r_shadow <= RST_DIV[i*DIV_W +: DIV_W];
        r_clk    <= 1'b0;
        r_tick   <= 1'b0;
        r_pend   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_active <= w_active_nxt;
        r_shadow <= w_shadow_nxt;
        r_clk    <= w_clk_nxt;
        r_tick   <= w_tick_nxt;
        r_pend   <= w_pend_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!ch_en[i]) begin
        w_state_nxt = c_idle;
        w_cnt_nxt   = '0;
      end else if ((r_state == c_idle) || w_sync || w_boundary) begin
        w_state_nxt = c_low;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt + DIV_W'(1);
        w_state_nxt = (w_cnt_nxt < w_low) ? c_low : c_high;
      end
    end

    // Outputs are computed for the coming cycle so they leave a flop.
    always_comb begin
      w_clk_nxt  = (w_state_nxt == c_high);
      w_tick_nxt = (w_state_nxt == c_high) && (w_cnt_nxt == w_ratio - DIV_W'(1));
    end

    // Shadow ratio is promoted only when no period is in flight.
    always_comb begin
      w_shadow_nxt = w_hit ? cfg_div : r_shadow;
      w_apply      = (r_state == c_idle) || w_boundary || w_sync;
      w_active_nxt = w_apply ? w_shadow_nxt : r_active;
      w_pend_nxt   = w_apply ? 1'b0 : (r_pend | w_hit);
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
    assign pending[i] = r_pend;
  end

endmodule

`default_nettype wire
